// File: rtl/rhd_acq_sequencer_if.sv
// rtl/rhd_acq_sequencer_if.sv - SPI pins and result stream of the RHD acquisition sequencer
interface rhd_acq_sequencer_if;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] sample_lo;
  logic [15:0] sample_hi;
  logic [5:0]  sample_ch;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output CS, SCLK, MOSI, sample_lo, sample_hi, sample_ch, sample_valid,
    input  MISO, sample_ready
  );

  modport slave (
    input  CS, SCLK, MOSI, sample_lo, sample_hi, sample_ch, sample_valid,
    output MISO, sample_ready
  );
endinterface

// File: rtl/rhd_acq_sequencer.sv
// rtl/rhd_acq_sequencer.sv - round-robin CONVERT sequencer for one RHD chip
// Each frame's DDR pair answers the command sent two frames earlier; a 2-deep history supplies the tag.
module rhd_acq_sequencer #(
  parameter int NUM_CH    = 32,
  parameter int SCLK_HALF = 4,
  parameter int SAMPLE_LO = 3,
  parameter int SAMPLE_HI = 7,
  parameter int CS_LEAD   = 2,
  parameter int CS_TRAIL  = 2,
  parameter int CS_HIGH   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  rhd_acq_sequencer_if.master        bus,
  output logic                       sweep_done,
  output logic                       overrun,
  input  logic                       clear_overrun
);
  localparam int BIT_CYC = 2 * SCLK_HALF;
  localparam int TW      = $clog2(BIT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] t_q, t_d;
  logic [3:0]    bit_q, bit_d;
  logic [5:0]    ptr_q, ptr_d;
  logic [5:0]    hist0_q, hist0_d, hist1_q, hist1_d;
  logic [1:0]    prime_q, prime_d;
  logic [15:0]   lo_sr_q, lo_sr_d, hi_sr_q, hi_sr_d;
  logic [15:0]   lo_q, lo_d, hi_q, hi_d;
  logic [5:0]    ch_q, ch_d;
  logic          valid_q, valid_d, sweep_q, sweep_d, ovr_q, ovr_d;
  logic [15:0]   cmd_word;
  logic [5:0]    prev_ptr;

  assign cmd_word = {2'b00, ptr_q, 8'h00};
  // The pointer has already advanced at the end of TRAIL, so the frame's own channel is one behind.
  assign prev_ptr = (ptr_q == 6'd0) ? 6'(NUM_CH - 1) : ptr_q - 6'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    bit_d   = bit_q;
    ptr_d   = ptr_q;
    prime_d = prime_q;
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    lo_sr_d = lo_sr_q;
    hi_sr_d = hi_sr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    sweep_d = 1'b0;
    ovr_d   = ovr_q;
    if (clear_overrun) ovr_d = 1'b0;
    if (valid_q && bus.sample_ready) valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ptr_d   = 6'd0;
        prime_d = 2'd0;
        cnt_d   = 16'd0;
        if (enable) state_d = S_LEAD;
      end
      S_LEAD: begin
        if (cnt_q == 16'(CS_LEAD - 1)) begin
          cnt_d   = 16'd0;
          t_d     = '0;
          bit_d   = 4'd0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT: begin
        if (t_q == TW'(SAMPLE_LO)) lo_sr_d = {lo_sr_q[14:0], bus.MISO};
        if (t_q == TW'(SAMPLE_HI)) hi_sr_d = {hi_sr_q[14:0], bus.MISO};
        if (t_q == TW'(BIT_CYC - 1)) begin
          t_d   = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = S_TRAIL;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == 16'(CS_TRAIL - 1)) begin
          cnt_d   = 16'd0;
          ptr_d   = (ptr_q == 6'(NUM_CH - 1)) ? 6'd0 : ptr_q + 6'd1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd0) begin
          if (prime_q == 2'd2) begin
            if (!valid_q || bus.sample_ready) begin
              lo_d    = lo_sr_q;
              hi_d    = hi_sr_q;
              ch_d    = hist1_q;
              valid_d = 1'b1;
              sweep_d = (hist1_q == 6'(NUM_CH - 1));
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            prime_d = prime_q + 2'd1;
          end
        end
        if (cnt_q == 16'(CS_HIGH - 1)) begin
          cnt_d   = 16'd0;
          hist1_d = hist0_q;
          hist0_d = prev_ptr;
          state_d = enable ? S_LEAD : S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      t_q     <= '0;
      bit_q   <= 4'd0;
      ptr_q   <= 6'd0;
      prime_q <= 2'd0;
      hist0_q <= 6'd0;
      hist1_q <= 6'd0;
      lo_sr_q <= 16'd0;
      hi_sr_q <= 16'd0;
      lo_q    <= 16'd0;
      hi_q    <= 16'd0;
      ch_q    <= 6'd0;
      valid_q <= 1'b0;
      sweep_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      prime_q <= prime_d;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      lo_sr_q <= lo_sr_d;
      hi_sr_q <= hi_sr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      sweep_q <= sweep_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.CS           = !(state_q inside {S_LEAD, S_SHIFT, S_TRAIL});
  assign bus.SCLK         = (state_q == S_SHIFT) && (t_q >= TW'(SCLK_HALF));
  assign bus.MOSI         = (state_q == S_SHIFT) && cmd_word[4'd15 - bit_q];
  assign bus.sample_lo    = lo_q;
  assign bus.sample_hi    = hi_q;
  assign bus.sample_ch    = ch_q;
  assign bus.sample_valid = valid_q;
  assign sweep_done       = sweep_q;
  assign overrun          = ovr_q;
endmodule

// File: tb/tb_rhd_acq_sequencer.sv
// tb/tb_rhd_acq_sequencer.sv - directed + randomized bench with a pin-level RHD chip and result model
module tb_rhd_acq_sequencer;
  localparam int NUM_CH    = 4;
  localparam int SCLK_HALF = 4;
  localparam int CS_LEAD   = 2;
  localparam int CS_TRAIL  = 2;
  localparam int CS_HIGH   = 8;
  localparam int FRAME     = CS_LEAD + 32 * SCLK_HALF + CS_TRAIL + CS_HIGH;
  localparam int LOW_LEN   = CS_LEAD + 32 * SCLK_HALF + CS_TRAIL;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic clear_overrun = 1'b0;
  logic sweep_done, overrun;

  rhd_acq_sequencer_if bus ();

  rhd_acq_sequencer #(
    .NUM_CH(NUM_CH), .SCLK_HALF(SCLK_HALF), .SAMPLE_LO(3), .SAMPLE_HI(7),
    .CS_LEAD(CS_LEAD), .CS_TRAIL(CS_TRAIL), .CS_HIGH(CS_HIGH)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus),
    .sweep_done(sweep_done), .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  // result-side reference
  logic        m_valid = 1'b0, m_ovr = 1'b0, m_sweep = 1'b0;
  logic [15:0] m_lo = '0, m_hi = '0;
  logic [5:0]  m_ch = '0;
  logic        arr = 1'b0;
  logic [15:0] a_lo = '0, a_hi = '0;
  logic [5:0]  a_ch = '0;
  // chip-side reference
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, aborted = 1'b1, fixed = 1'b1;
  int          high_cnt = 0, low_cnt = 0, frame_k = 0, nbit = 0, rises = 0;
  logic [15:0] cur_lo = '0, cur_hi = '0, mosi_w = '0;
  int          c1;
  logic [15:0] held_lo, held_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic rdy, clr, rst_n, drop;
    rdy   = bus.sample_ready;
    clr   = clear_overrun;
    rst_n = rstn;
    @(posedge clk);
    #1;
    cyc++;
    drop = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_sweep = 1'b0;
      m_lo = '0; m_hi = '0; m_ch = '0; arr = 1'b0; aborted = 1'b1;
    end else begin
      m_sweep = 1'b0;
      if (arr) begin
        if (!m_valid || rdy) begin
          m_valid = 1'b1; m_lo = a_lo; m_hi = a_hi; m_ch = a_ch;
          m_sweep = (a_ch == 6'(NUM_CH - 1));
        end else begin
          drop = 1'b1; m_ovr = 1'b1;
        end
        arr = 1'b0;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (clr && !drop) m_ovr = 1'b0;
    end
    // A CS-high stretch of exactly CS_HIGH means back-to-back frames; anything else starts a new run.
    if (prev_cs && !bus.CS) begin
      frame_k  = (high_cnt == CS_HIGH) ? frame_k + 1 : 0;
      high_cnt = 0; low_cnt = 0; nbit = 0; rises = 0; mosi_w = '0; aborted = 1'b0;
      cur_lo = fixed ? 16'h1234 : 16'($urandom);
      cur_hi = fixed ? 16'hABCD : 16'($urandom);
    end
    if (!prev_cs && bus.CS && !aborted) begin
      chk("cs_low_len", 32'(low_cnt), 32'(LOW_LEN));
      chk("sclk_pulses", 32'(rises), 32'd16);
      chk("mosi_cmd", 32'(mosi_w), 32'({2'b00, 6'(frame_k % NUM_CH), 8'h00}));
      if (frame_k >= 2) begin
        arr = 1'b1; a_lo = cur_lo; a_hi = cur_hi; a_ch = 6'((frame_k - 2) % NUM_CH);
      end
    end
    if (bus.CS) begin
      high_cnt++;
      chk("idle_sclk", 32'(bus.SCLK), 32'd0);
      chk("idle_mosi", 32'(bus.MOSI), 32'd0);
    end else begin
      low_cnt++;
      if (!prev_sclk && bus.SCLK) begin
        rises++;
        mosi_w = {mosi_w[14:0], bus.MOSI};
      end
      if (prev_sclk && !bus.SCLK) nbit++;
    end
    bus.MISO = (!bus.CS && nbit < 16) ? (bus.SCLK ? cur_hi[15 - nbit] : cur_lo[15 - nbit]) : 1'b0;
    chk("valid", 32'(bus.sample_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("sweep_done", 32'(sweep_done), 32'(m_sweep));
    if (m_valid) begin
      chk("sample_lo", 32'(bus.sample_lo), 32'(m_lo));
      chk("sample_hi", 32'(bus.sample_hi), 32'(m_hi));
      chk("sample_ch", 32'(bus.sample_ch), 32'(m_ch));
    end
    prev_cs   = bus.CS;
    prev_sclk = bus.SCLK;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (bus.sample_valid !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, 32'(bus.sample_valid), 32'd1);
  endtask

  task automatic wait_sweep(input int budget);
    int n = 0;
    while (sweep_done !== 1'b1 && n < budget) begin tick(); n++; end
    chk("wait_sweep", 32'(sweep_done), 32'd1);
  endtask

  task automatic wait_cs(input logic lvl, input int budget);
    int n = 0;
    while (bus.CS !== lvl && n < budget) begin tick(); n++; end
    chk("wait_cs", 32'(bus.CS), 32'(lvl));
  endtask

  initial begin
    bus.MISO = 1'b0;
    bus.sample_ready = 1'b1;
    enable = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_cs", 32'(bus.CS), 32'd1);
    chk("rst_sclk", 32'(bus.SCLK), 32'd0);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_lo", 32'(bus.sample_lo), 32'd0);
    chk("rst_hi", 32'(bus.sample_hi), 32'd0);
    chk("rst_ch", 32'(bus.sample_ch), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);

    rstn = 1'b1;
    tick();
    chk("cs_fall_after_reset", 32'(bus.CS), 32'd0);

    wait_valid(3 * FRAME + 10, "first_valid");
    chk("first_ch", 32'(bus.sample_ch), 32'd0);
    chk("first_lo", 32'(bus.sample_lo), 32'h1234);
    chk("first_hi", 32'(bus.sample_hi), 32'hABCD);
    c1 = cyc;
    tick();
    wait_valid(FRAME + 10, "second_valid");
    chk("valid_period", 32'(cyc - c1), 32'(FRAME));
    chk("second_ch", 32'(bus.sample_ch), 32'd1);

    fixed = 1'b0;
    tick();
    wait_sweep(NUM_CH * FRAME + 10);
    chk("sweep_ch", 32'(bus.sample_ch), 32'(NUM_CH - 1));
    tick();
    wait_valid(FRAME + 10, "wrap_valid");
    chk("wrap_ch", 32'(bus.sample_ch), 32'd0);

    tick();
    bus.sample_ready = 1'b0;
    wait_valid(FRAME + 10, "held_valid");
    held_lo = bus.sample_lo;
    held_hi = bus.sample_hi;
    repeat (250) tick();
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_held_lo", 32'(bus.sample_lo), 32'(held_lo));
    chk("bp_held_hi", 32'(bus.sample_hi), 32'(held_hi));
    chk("bp_valid", 32'(bus.sample_valid), 32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    bus.sample_ready = 1'b1;
    tick();
    chk("released", 32'(bus.sample_valid), 32'd0);

    wait_cs(1'b1, FRAME);
    wait_cs(1'b0, FRAME);
    repeat (60) tick();
    enable = 1'b0;
    wait_cs(1'b1, FRAME);
    repeat (20) tick();
    chk("idle_after_disable", 32'(bus.CS), 32'd1);
    enable = 1'b1;
    wait_valid(3 * FRAME + 10, "reenable_valid");
    chk("reenable_ch", 32'(bus.sample_ch), 32'd0);

    tick();
    wait_cs(1'b1, FRAME);
    wait_cs(1'b0, FRAME);
    repeat (50) tick();
    rstn = 1'b0;
    tick();
    chk("midreset_cs", 32'(bus.CS), 32'd1);
    chk("midreset_valid", 32'(bus.sample_valid), 32'd0);
    repeat (11) tick();
    rstn = 1'b1;
    wait_valid(3 * FRAME + 10, "post_reset_valid");
    chk("post_reset_ch", 32'(bus.sample_ch), 32'd0);
    repeat (FRAME) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rhd_acq_sequencer.md
Name: rhd_acq_sequencer

Overview:
SPI master that sequences one RHD-style amplifier chip through a continuous round-robin of CONVERT commands. It generates CS, SCLK and MOSI, and captures the double-data-rate MISO stream, which carries two 16-bit words per frame: the lo word for channel c and the hi word for channel c+32. The two-frame command-to-result pipeline is tracked so every captured pair is tagged with its channel. Results go to the downstream packetiser over a valid/ready interface.

Parameters:
NUM_CH, 32, channels per sweep on the lo half (1..32); the command channel wraps NUM_CH-1 -> 0
SCLK_HALF, 4, clk cycles per SCLK phase (>=2); bit period = 2*SCLK_HALF
SAMPLE_LO, 3, clk offset within a bit period at which MISO is captured into the lo word (0..2*SCLK_HALF-1)
SAMPLE_HI, 7, clk offset within a bit period at which MISO is captured into the hi word (!= SAMPLE_LO)
CS_LEAD, 2, clk cycles between CS falling and the first SCLK low phase
CS_TRAIL, 2, clk cycles between the last bit period and CS rising
CS_HIGH, 8, minimum clk cycles CS stays high between frames

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
enable  in  1  run continuous acquisition while high
MISO  in  1  DDR serial data from the chip
CS  out  1  chip select, active-low
SCLK  out  1  serial clock
MOSI  out  1  command data, MSB first
sample_lo  out  16  captured lo word
sample_hi  out  16  captured hi word
sample_ch  out  6  lo channel index of the pair (hi channel = sample_ch+32)
sample_valid  out  1  pair available
sample_ready  in  1  downstream accepts
sweep_done  out  1  one-cycle pulse when the pair for channel NUM_CH-1 is made valid
overrun  out  1  sticky: a completed pair was dropped
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset values (rstn=0 at posedge clk): state IDLE, CS=1, SCLK=0, MOSI=0, sample_valid=0, sample_lo/hi=0, sample_ch=0, sweep_done=0, overrun=0. Command channel pointer=0, prime count=0. Reset mid-frame aborts immediately; CS rises on the next edge.
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> (LEAD if enable else IDLE).
  - IDLE: leave when enable=1.
  - LEAD: CS=0 for CS_LEAD cycles.
  - SHIFT: 16 bit periods.
  - TRAIL: CS=0 for CS_TRAIL cycles.
  - GAP: CS=1 for CS_HIGH cycles.
- enable is sampled only in IDLE and at the last GAP cycle. Dropping enable mid-frame completes the frame.
- Frame length = CS_LEAD + 32*SCLK_HALF + CS_TRAIL + CS_HIGH; 140 clk at defaults.
- Bit timing: bit-cycle index t=0..2*SCLK_HALF-1. SCLK=0 for t<SCLK_HALF and 1 otherwise. MOSI updates at t=0, MSB first.
- Command word = {2'b00, ch[5:0], 8'h00}, with ch = command channel pointer. The pointer increments at end of TRAIL and wraps NUM_CH-1 -> 0.
- Capture: at t=SAMPLE_LO, shift MISO into lo_sr (MSB first); at t=SAMPLE_HI, shift into hi_sr. After 16 bit periods each register holds a full word.
- Pipeline: the pair captured in frame k answers the command of frame k-2. The tag is held in a 2-deep channel history.
  - The first 2 frames after leaving IDLE are priming frames: their data is discarded and no valid is raised. Prime count saturates at 2.
  - Entering IDLE resets the pointer and prime count to 0, so the last 2 results are lost on disable.
- Output: on the first GAP cycle of a non-priming frame:
  - if sample_valid=0 or sample_ready=1 that cycle, load sample_lo/hi/ch, set sample_valid=1, and pulse sweep_done if the tag = NUM_CH-1;
  - otherwise drop the new pair, keep the old pair, set overrun=1, and do not pulse sweep_done.
- sample_valid clears on a valid&&ready cycle unless a new pair loads that same cycle (load wins, valid stays 1).
- overrun clears only on rstn=0 or clear_overrun=1. If clear and a drop occur in the same cycle, set wins.
- The SCLK/MOSI idle level outside SHIFT is 0.

Test Plan:
- Reset/idle: rstn=0 with enable=1 -> CS=1, SCLK=0, all outputs 0. After release, CS falls 1 cycle later; 16 SCLK pulses of 8 clk each.
- Command sequence: NUM_CH=4, capture MOSI over 6 frames -> words 0x0000, 0x0100, 0x0200, 0x0300, 0x0000, 0x0100.
- DDR capture: RHD model drives lo=0x1234, hi=0xABCD every frame, sample_ready=1 -> first valid in frame 3 with sample_ch=0. Then ch increments each frame; pairs are exact; valid period = 140 clk.
- Sweep/wrap: NUM_CH=32 -> sweep_done pulses with sample_ch=31, then sample_ch=0 follows.
- Backpressure: hold sample_ready=0 across 2 result frames -> first pair held stable, second dropped, overrun=1. clear_overrun -> 0; pulsing ready releases the held pair.
- Disable/reset mid-frame: enable=0 at mid-SHIFT -> the frame completes, then IDLE. Re-enable -> 2 priming frames, channel 0 first. rstn=0 mid-SHIFT -> CS=1 on the next cycle, valid=0.
